// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and constants for the reservation-station issue scheduler.
package rs_issue_scheduler_pkg;

  localparam int RS_DEPTH = 16;
  localparam int NUM_FU   = 3;
  localparam int PREG_W   = 6;
  localparam int ROB_W    = 4;
  localparam int OP_W     = 7;
  localparam int IDX_W    = $clog2(RS_DEPTH);
  localparam int FU_W     = 2;
  localparam int CNT_W    = IDX_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic              ps1_rdy;
    logic [PREG_W-1:0] ps2;
    logic              ps2_rdy;
    logic [FU_W-1:0]   fu_index;
    logic [ROB_W-1:0]  rob_index;
  } rs_alloc_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [ROB_W-1:0]  rob_index;
  } rs_issue_t;

  // True when tag matches either valid writeback broadcast.
  function automatic logic wb_hit(input logic [1:0] wb_valid,
                                  input logic [1:0][PREG_W-1:0] wb_preg,
                                  input logic [PREG_W-1:0] tag);
    return (wb_valid[0] && (wb_preg[0] == tag)) ||
           (wb_valid[1] && (wb_preg[1] == tag));
  endfunction

endpackage

// File: rtl/rs_issue_scheduler_rr_picker.sv
// Circular priority select: first set bit of req scanning upward from base, wrapping.
module rr_picker
  import rs_issue_scheduler_pkg::*;
(
  input  logic [RS_DEPTH-1:0] req,
  input  logic [IDX_W-1:0]    base,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);

  logic [IDX_W-1:0] k;
  logic             hit;

  // Scan offsets 0..RS_DEPTH-1 from base; IDX_W-bit addition gives the wrap for free.
  always_comb begin
    found = 1'b0;
    idx   = base;
    k     = base;
    hit   = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      k     = base + IDX_W'(i);
      hit   = req[k] & ~found;
      idx   = hit ? k : idx;
      found = found | hit;
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// 16-row reservation station: 2-wide allocation, tag wakeup, per-FU round-robin issue.
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    alloc_valid,
  input  rs_alloc_t [1:0]               alloc_entry,
  output logic                          alloc_ready,
  output logic [4:0]                    free_cnt,
  input  logic [1:0]                    wb_valid,
  input  logic [1:0][PREG_W-1:0]        wb_preg,
  output logic [NUM_FU-1:0]             iss_valid,
  input  logic [NUM_FU-1:0]             iss_ready,
  output rs_issue_t [NUM_FU-1:0]        iss_pkt,
  output logic                          err_fu
);

  logic [RS_DEPTH-1:0]               in_use;
  logic [RS_DEPTH-1:0]               src1_rdy;
  logic [RS_DEPTH-1:0]               src2_rdy;
  rs_issue_t                         payload [RS_DEPTH];
  logic [FU_W-1:0]                   fu_sel  [RS_DEPTH];

  logic [NUM_FU-1:0][IDX_W-1:0]      rr_ptr;
  logic [NUM_FU-1:0][IDX_W-1:0]      lock_idx;
  logic [NUM_FU-1:0]                 lock_v;
  logic [NUM_FU-1:0][IDX_W-1:0]      pick_idx;
  logic [NUM_FU-1:0]                 pick_found;
  logic [NUM_FU-1:0][IDX_W-1:0]      sel_idx;
  logic [NUM_FU-1:0]                 fire;
  logic [NUM_FU-1:0][RS_DEPTH-1:0]   elig;

  logic [RS_DEPTH-1:0]               wake1;
  logic [RS_DEPTH-1:0]               wake2;
  logic [RS_DEPTH-1:0]               free1_req;
  logic                              free0_found;
  logic                              free1_found;
  logic [IDX_W-1:0]                  free0_idx;
  logic [IDX_W-1:0]                  free1_idx;
  logic [1:0]                        do_alloc;
  logic [1:0][IDX_W-1:0]             alloc_idx;
  logic [CNT_W-1:0]                  n_alloc;
  logic [CNT_W-1:0]                  n_issue;

  assign alloc_ready = (free_cnt >= CNT_W'(2));

  // Slot 0 gets the lowest free row, slot 1 the next one up.
  rr_picker u_free0 (.req(~in_use),   .base({IDX_W{1'b0}}), .found(free0_found), .idx(free0_idx));
  assign free1_req = ~in_use & ~(RS_DEPTH'(1) << free0_idx);
  rr_picker u_free1 (.req(free1_req), .base({IDX_W{1'b0}}), .found(free1_found), .idx(free1_idx));

  assign do_alloc[0]  = alloc_valid[0] & alloc_ready & free0_found;
  assign do_alloc[1]  = alloc_valid[1] & alloc_ready & free1_found;
  assign alloc_idx[0] = free0_idx;
  assign alloc_idx[1] = free1_idx;

  // Per-row wakeup matches and per-FU eligibility, all from registered state.
  always_comb begin
    wake1 = {RS_DEPTH{1'b0}};
    wake2 = {RS_DEPTH{1'b0}};
    elig  = {(NUM_FU*RS_DEPTH){1'b0}};
    for (int r = 0; r < RS_DEPTH; r++) begin
      wake1[r] = wb_hit(wb_valid, wb_preg, payload[r].ps1);
      wake2[r] = wb_hit(wb_valid, wb_preg, payload[r].ps2);
      for (int f = 0; f < NUM_FU; f++) begin
        elig[f][r] = in_use[r] & src1_rdy[r] & src2_rdy[r] & (fu_sel[r] == FU_W'(f));
      end
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
    rr_picker u_pick (.req(elig[f]), .base(rr_ptr[f]), .found(pick_found[f]), .idx(pick_idx[f]));
    // A stalled FU keeps presenting its locked row so the packet cannot change under it.
    assign sel_idx[f]   = lock_v[f] ? lock_idx[f] : pick_idx[f];
    assign iss_valid[f] = ~rst & (lock_v[f] | pick_found[f]);
    assign iss_pkt[f]   = payload[sel_idx[f]];
    assign fire[f]      = iss_valid[f] & iss_ready[f];
  end

  // Allocation and issue counts for the free-row counter.
  always_comb begin
    n_alloc = CNT_W'(do_alloc[0]) + CNT_W'(do_alloc[1]);
    n_issue = {CNT_W{1'b0}};
    for (int f = 0; f < NUM_FU; f++) begin
      n_issue = n_issue + CNT_W'(fire[f]);
    end
  end

  // Row occupancy, readiness, round-robin pointers, stall locks and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_use   <= {RS_DEPTH{1'b0}};
      src1_rdy <= {RS_DEPTH{1'b0}};
      src2_rdy <= {RS_DEPTH{1'b0}};
      rr_ptr   <= {(NUM_FU*IDX_W){1'b0}};
      lock_idx <= {(NUM_FU*IDX_W){1'b0}};
      lock_v   <= {NUM_FU{1'b0}};
      err_fu   <= 1'b0;
      free_cnt <= CNT_W'(RS_DEPTH);
    end else begin
      src1_rdy <= src1_rdy | (in_use & wake1);
      src2_rdy <= src2_rdy | (in_use & wake2);
      for (int f = 0; f < NUM_FU; f++) begin
        if (fire[f]) begin
          in_use[sel_idx[f]] <= 1'b0;
          rr_ptr[f]          <= sel_idx[f] + IDX_W'(1);
          lock_v[f]          <= 1'b0;
        end else if (iss_valid[f]) begin
          lock_v[f]   <= 1'b1;
          lock_idx[f] <= sel_idx[f];
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (do_alloc[s]) begin
          in_use[alloc_idx[s]]   <= 1'b1;
          src1_rdy[alloc_idx[s]] <= alloc_entry[s].ps1_rdy | wb_hit(wb_valid, wb_preg, alloc_entry[s].ps1);
          src2_rdy[alloc_idx[s]] <= alloc_entry[s].ps2_rdy | wb_hit(wb_valid, wb_preg, alloc_entry[s].ps2);
          if (alloc_entry[s].fu_index >= FU_W'(NUM_FU)) begin
            err_fu <= 1'b1;
          end
        end
      end
      free_cnt <= free_cnt - n_alloc + n_issue;
    end
  end

  // Entry payload; only meaningful while the row is in use, so no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (do_alloc[s]) begin
        payload[alloc_idx[s]] <= {alloc_entry[s].op, alloc_entry[s].pd, alloc_entry[s].ps1,
                                  alloc_entry[s].ps2, alloc_entry[s].rob_index};
        fu_sel[alloc_idx[s]]  <= alloc_entry[s].fu_index;
      end
    end
  end

endmodule
